// File: rtl/lcd_frame_sched_if.sv
// lcd_frame_sched_if: byte front end, FIFO write side and frame status of the frame scheduler
interface lcd_frame_sched_if;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_dc;
  logic [7:0] byte_data;
  logic       fifo_full;
  logic       fifo_we;
  logic [7:0] fifo_di;
  logic       fifo_rst;
  logic       frame_start;
  logic       frame_done;
  logic       frame_abort;
  logic       overflow;
  logic       win_err;
  logic       busy;
  modport master (
    output byte_valid, byte_dc, byte_data, fifo_full,
    input  byte_ready, fifo_we, fifo_di, fifo_rst, frame_start, frame_done,
           frame_abort, overflow, win_err, busy
  );
  modport slave (
    input  byte_valid, byte_dc, byte_data, fifo_full,
    output byte_ready, fifo_we, fifo_di, fifo_rst, frame_start, frame_done,
           frame_abort, overflow, win_err, busy
  );
endinterface

// File: rtl/lcd_frame_sched.sv
// lcd_frame_sched: DCS command decoder and window-sized pixel byte streamer into the display FIFO
module lcd_frame_sched #(
  parameter int H_RES        = 800,
  parameter int V_RES        = 480,
  parameter int FLUSH_CYCLES = 4
) (
  input logic              CLK,
  input logic              RST,
  lcd_frame_sched_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARG    = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;
  localparam logic [15:0] H_MAX  = 16'(H_RES - 1);
  localparam logic [15:0] V_MAX  = 16'(V_RES - 1);
  localparam logic [3:0]  F_LAST = 4'(FLUSH_CYCLES - 1);
  logic [1:0]  r_state;
  logic        r_tgt;
  logic [1:0]  r_idx;
  logic [23:0] r_arg;
  logic [15:0] r_sc, r_ec, r_sr, r_er;
  logic [31:0] r_cnt;
  logic [3:0]  r_fcnt;
  logic        r_we;
  logic [7:0]  r_di;
  logic        r_start, r_done, r_abort, r_ovf, r_werr;
  logic        w_xfer, w_cmd, w_data, w_win_ok;
  logic [15:0] w_end, w_end_c;
  logic [31:0] w_len;
  assign w_xfer   = bus.byte_valid & bus.byte_ready;
  assign w_cmd    = w_xfer & ~bus.byte_dc;
  assign w_data   = w_xfer & bus.byte_dc;
  assign w_win_ok = (r_sc <= r_ec) && (r_sr <= r_er);
  assign w_len    = (({16'd0, r_ec} - {16'd0, r_sc} + 32'd1) *
                     ({16'd0, r_er} - {16'd0, r_sr} + 32'd1)) << 1;
  assign w_end    = {r_arg[7:0], bus.byte_data};
  // only the end coordinate is clamped so an out-of-range start still makes the window invalid
  assign w_end_c  = r_tgt ? ((w_end > V_MAX) ? V_MAX : w_end)
                          : ((w_end > H_MAX) ? H_MAX : w_end);
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_tgt   <= 1'b0;
      r_idx   <= 2'd0;
      r_arg   <= 24'd0;
      r_sc    <= 16'd0;
      r_ec    <= H_MAX;
      r_sr    <= 16'd0;
      r_er    <= V_MAX;
      r_cnt   <= 32'd0;
      r_fcnt  <= 4'd0;
      r_we    <= 1'b0;
      r_di    <= 8'd0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_ovf   <= 1'b0;
      r_werr  <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      if (w_cmd) begin
        r_abort <= (r_state == S_STREAM);
        r_state <= S_IDLE;
        if (bus.byte_data == 8'h2A || bus.byte_data == 8'h2B) begin
          r_tgt   <= bus.byte_data[0];
          r_idx   <= 2'd0;
          r_state <= S_ARG;
        end else if (bus.byte_data == 8'h2C) begin
          if (w_win_ok) begin
            r_ovf   <= 1'b0;
            r_cnt   <= w_len;
            r_fcnt  <= F_LAST;
            r_state <= S_FLUSH;
          end else begin
            r_werr <= 1'b1;
          end
        end
      end else if (r_state == S_FLUSH) begin
        r_fcnt <= r_fcnt - 4'd1;
        if (r_fcnt == 4'd0) begin
          r_state <= S_STREAM;
          r_start <= 1'b1;
        end
      end else if (w_data && r_state == S_ARG) begin
        r_idx <= r_idx + 2'd1;
        r_arg <= {r_arg[15:0], bus.byte_data};
        if (r_idx == 2'd3) begin
          r_state <= S_IDLE;
          if (r_tgt) begin
            r_sr <= r_arg[23:8];
            r_er <= w_end_c;
          end else begin
            r_sc <= r_arg[23:8];
            r_ec <= w_end_c;
          end
        end
      end else if (w_data && r_state == S_STREAM) begin
        // dropped bytes still count so the frame stays aligned to the window
        r_cnt <= r_cnt - 32'd1;
        r_we  <= ~bus.fifo_full;
        r_di  <= bus.byte_data;
        r_ovf <= r_ovf | bus.fifo_full;
        if (r_cnt == 32'd1) begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      end
    end
  end
  assign bus.byte_ready  = (r_state != S_FLUSH);
  assign bus.busy        = r_state[1];
  assign bus.fifo_rst    = (r_state == S_FLUSH);
  assign bus.fifo_we     = r_we;
  assign bus.fifo_di     = r_di;
  assign bus.frame_start = r_start;
  assign bus.frame_done  = r_done;
  assign bus.frame_abort = r_abort;
  assign bus.overflow    = r_ovf;
  assign bus.win_err     = r_werr;
endmodule

// File: tb/tb_lcd_frame_sched.sv
// tb_lcd_frame_sched: directed table plus hand sequences for the frame scheduler on a 32x8 panel
module tb_lcd_frame_sched;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  lcd_frame_sched_if bus();
  lcd_frame_sched #(.H_RES(32), .V_RES(8), .FLUSH_CYCLES(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  typedef struct {
    logic       dc;
    logic [7:0] d;
    logic       full;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];
  int tests = 0;
  int fails = 0;
  int n_we = 0, n_done = 0, n_start = 0, n_abort = 0, run = 0, start_run = 0;
  always @(negedge CLK) begin
    if (bus.fifo_we) n_we++;
    if (bus.frame_done) n_done++;
    if (bus.frame_start) n_start++;
    if (bus.frame_abort) n_abort++;
    if (bus.fifo_rst) run++;
    else begin
      if (bus.frame_start) start_run = run;
      run = 0;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic dc, input logic [7:0] d);
    int n;
    n = 0;
    while (!bus.byte_ready && n < 64) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.byte_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    bus.byte_dc    = dc;
    bus.byte_data  = d;
    bus.byte_valid = 1'b1;
    @(negedge CLK);
    bus.byte_valid = 1'b0;
  endtask
  task automatic add(input logic dc, input logic [7:0] d, input logic full, input logic [5:0] exp);
    vec_t v;
    v.dc = dc; v.d = d; v.full = full; v.exp = exp;
    tbl.push_back(v);
  endtask
  function automatic logic [5:0] flags();
    return {bus.fifo_we, bus.frame_done, bus.frame_abort, bus.busy, bus.overflow, bus.win_err};
  endfunction
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int b_we, b_done, b_start, b_abort;
    // exp = {we, done, abort, busy, overflow, win_err}
    add(0, 8'h00, 0, 6'b000000); add(1, 8'h77, 0, 6'b000000);
    add(0, 8'h2A, 0, 6'b000000); add(1, 8'h00, 0, 6'b000000); add(1, 8'h05, 0, 6'b000000);
    add(1, 8'h00, 0, 6'b000000); add(1, 8'h06, 0, 6'b000000);
    add(0, 8'h2B, 0, 6'b000000); add(1, 8'h00, 0, 6'b000000); add(1, 8'h03, 0, 6'b000000);
    add(1, 8'h00, 0, 6'b000000); add(1, 8'h03, 0, 6'b000000);
    add(0, 8'h2C, 0, 6'b000100);
    add(1, 8'hA1, 0, 6'b100100); add(1, 8'hB2, 1, 6'b000110);
    add(1, 8'hC3, 0, 6'b100110); add(1, 8'hD4, 0, 6'b110010);
    add(1, 8'hE5, 0, 6'b000010);
    add(0, 8'h2C, 0, 6'b000100);
    add(1, 8'h11, 0, 6'b100100); add(1, 8'h22, 0, 6'b100100);
    add(1, 8'h33, 0, 6'b100100); add(1, 8'h44, 0, 6'b110000);
    add(0, 8'h2A, 0, 6'b000000); add(1, 8'h04, 0, 6'b000000); add(1, 8'h00, 0, 6'b000000);
    add(1, 8'h05, 0, 6'b000000); add(1, 8'h00, 0, 6'b000000);
    add(0, 8'h2C, 0, 6'b000001); add(1, 8'h55, 0, 6'b000001);
    add(0, 8'h2A, 0, 6'b000001); add(1, 8'h00, 0, 6'b000001); add(1, 8'h05, 0, 6'b000001);
    add(1, 8'h00, 0, 6'b000001); add(1, 8'h06, 0, 6'b000001);
    add(0, 8'h2A, 0, 6'b000001); add(1, 8'h00, 0, 6'b000001); add(1, 8'h00, 0, 6'b000001);
    add(0, 8'h2C, 0, 6'b000101);
    add(1, 8'h61, 0, 6'b100101); add(1, 8'h62, 0, 6'b100101);
    add(1, 8'h63, 0, 6'b100101); add(1, 8'h64, 0, 6'b110001);
    bus.byte_valid = 1'b0;
    bus.byte_dc    = 1'b0;
    bus.byte_data  = 8'h00;
    bus.fifo_full  = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {23'd0, bus.byte_ready, bus.busy, bus.fifo_rst, bus.fifo_we,
        bus.frame_start, bus.frame_done, bus.frame_abort, bus.overflow, bus.win_err}, 32'h100);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_ready", {31'd0, bus.byte_ready}, 32'd1);
    foreach (tbl[i]) begin
      bus.fifo_full = tbl[i].full;
      send(tbl[i].dc, tbl[i].d);
      chk($sformatf("vec%0d_flags", i), {26'd0, flags()}, {26'd0, tbl[i].exp});
      if (tbl[i].exp[5]) chk($sformatf("vec%0d_di", i), {24'd0, bus.fifo_di}, {24'd0, tbl[i].d});
    end
    bus.fifo_full = 1'b0;
    // 10x2 window: 40 bytes, 41st ignored
    send(0, 8'h2A); send(1, 8'h00); send(1, 8'h0A); send(1, 8'h00); send(1, 8'h13);
    send(0, 8'h2B); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00); send(1, 8'h01);
    #1;
    b_start = n_start; b_done = n_done; b_we = n_we;
    @(negedge CLK);
    send(0, 8'h2C);
    for (int i = 0; i < 40; i++) begin
      send(1, 8'(i + 8'h10));
      chk($sformatf("w40_b%0d", i), {22'd0, bus.fifo_we, bus.frame_done, bus.fifo_di},
          {22'd0, 1'b1, 1'(i == 39), 8'(i + 8'h10)});
    end
    send(1, 8'hEE);
    chk("w40_extra_we", {31'd0, bus.fifo_we}, 32'd0);
    #1;
    chk("w40_flush_len", start_run, 4);
    chk("w40_starts", n_start - b_start, 1);
    chk("w40_dones", n_done - b_done, 1);
    chk("w40_writes", n_we - b_we, 40);
    @(negedge CLK);
    // abort after 6 bytes, then restart with a full 40-byte frame
    send(0, 8'h2C);
    for (int i = 0; i < 6; i++) send(1, 8'(i));
    #1;
    b_done = n_done; b_abort = n_abort;
    @(negedge CLK);
    send(0, 8'h2C);
    chk("abort_pulse", {29'd0, bus.frame_abort, bus.fifo_rst, bus.frame_done}, 32'b110);
    for (int i = 0; i < 40; i++) begin
      send(1, 8'(8'hC0 + i));
      chk($sformatf("reload_b%0d", i), {30'd0, bus.fifo_we, bus.frame_done}, {30'd0, 1'b1, 1'(i == 39)});
    end
    #1;
    chk("abort_count", n_abort - b_abort, 1);
    chk("abort_dones", n_done - b_done, 1);
    chk("abort_flush_len", start_run, 4);
    @(negedge CLK);
    // reset in flush cycle 2, then the default 32x8 window yields 512 bytes
    send(0, 8'h2C);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_flush", {29'd0, bus.fifo_rst, bus.busy, bus.byte_ready}, 32'b001);
    chk("rst_flags", {26'd0, flags()}, 32'd0);
    send(0, 8'h2C);
    for (int i = 0; i < 512; i++) begin
      send(1, 8'(i * 7));
      chk($sformatf("dflt_b%0d", i), {30'd0, bus.fifo_we, bus.frame_done}, {30'd0, 1'b1, 1'(i == 511)});
    end
    chk("dflt_idle", {30'd0, bus.busy, bus.byte_ready}, 32'b01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
